// File: rtl/assign_range_if.sv
// Range-record in / bit-connection out bus for the assign range expander.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the record side, out_valid/out_ready on the beat side.
interface assign_range_if #(
    parameter int IDX_W = 8
);
    // record side
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_sink_msb;
    logic [IDX_W-1:0] in_sink_lsb;
    logic [IDX_W-1:0] in_src_msb;
    logic [IDX_W-1:0] in_src_lsb;
    // beat side
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_sink_idx;
    logic [IDX_W-1:0] out_src_idx;
    logic             out_last;

    // Producer of records / consumer of beats.
    modport master (
        output in_valid, in_sink_msb, in_sink_lsb, in_src_msb, in_src_lsb, out_ready,
        input  in_ready, out_valid, out_sink_idx, out_src_idx, out_last
    );

    // The expander itself.
    modport slave (
        input  in_valid, in_sink_msb, in_sink_lsb, in_src_msb, in_src_lsb, out_ready,
        output in_ready, out_valid, out_sink_idx, out_src_idx, out_last
    );
endinterface

// File: rtl/assign_range_expander.sv
// Expands sink[msb:lsb] = source[msb:lsb] records into one (sink bit, source bit) beat per cycle.
// Latency: first beat one cycle after accept; N beats occupy N cycles, idle again one cycle later.
// Backpressure: registered beat holds while out_ready is low; in_ready only in IDLE, so records wait upstream.
// Ports: clk/rst (sync, active-high); bus (slave modport) carries record in and beat out;
//        err_pulse/err_count report width-mismatched records; busy is high while expanding.
module assign_range_expander #(
    parameter int IDX_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    assign_range_if.slave    bus,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        REJECT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [IDX_W-1:0]   sink_idx_q, sink_idx_d;
    logic [IDX_W-1:0]   src_idx_q, src_idx_d;
    logic [IDX_W:0]     rem_q, rem_d;
    logic               sink_dn_q, sink_dn_d;
    logic               src_dn_q, src_dn_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic               in_ready;
    logic               accept;
    logic               beat_hs;
    logic               in_sink_dn;
    logic               in_src_dn;
    logic [IDX_W:0]     w_sink;
    logic [IDX_W:0]     w_src;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = bus.in_valid && in_ready;
    assign beat_hs  = out_valid_q && bus.out_ready;

    // Widths are |msb - lsb| + 1 in IDX_W+1 bits, so a full 2^IDX_W range fits.
    always_comb begin
        in_sink_dn = bus.in_sink_msb >= bus.in_sink_lsb;
        in_src_dn  = bus.in_src_msb >= bus.in_src_lsb;
        w_sink = in_sink_dn ? ({1'b0, bus.in_sink_msb} - {1'b0, bus.in_sink_lsb} + (IDX_W+1)'(1))
                            : ({1'b0, bus.in_sink_lsb} - {1'b0, bus.in_sink_msb} + (IDX_W+1)'(1));
        w_src  = in_src_dn  ? ({1'b0, bus.in_src_msb} - {1'b0, bus.in_src_lsb} + (IDX_W+1)'(1))
                            : ({1'b0, bus.in_src_lsb} - {1'b0, bus.in_src_msb} + (IDX_W+1)'(1));
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sink_idx_d  = sink_idx_q;
        src_idx_d   = src_idx_q;
        rem_d       = rem_q;
        sink_dn_d   = sink_dn_q;
        src_dn_d    = src_dn_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (w_sink != w_src) begin
                        state_d     = REJECT;
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end else begin
                        state_d     = EXPAND;
                        out_valid_d = 1'b1;
                        sink_idx_d  = bus.in_sink_msb;
                        src_idx_d   = bus.in_src_msb;
                        sink_dn_d   = in_sink_dn;
                        src_dn_d    = in_src_dn;
                        rem_d       = w_sink - (IDX_W+1)'(1);
                        out_last_d  = (w_sink == (IDX_W+1)'(1));
                    end
                end
            end
            EXPAND: begin
                if (beat_hs) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        // Only non-final beats step, so an index never moves past its lsb
                        // and no emitted index wraps at 0 or 2^IDX_W-1.
                        rem_d      = rem_q - (IDX_W+1)'(1);
                        out_last_d = (rem_q == (IDX_W+1)'(1));
                        sink_idx_d = sink_dn_q ? sink_idx_q - IDX_W'(1) : sink_idx_q + IDX_W'(1);
                        src_idx_d  = src_dn_q  ? src_idx_q - IDX_W'(1)  : src_idx_q + IDX_W'(1);
                    end
                end
            end
            REJECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sink_idx_q  <= '0;
            src_idx_q   <= '0;
            rem_q       <= '0;
            sink_dn_q   <= 1'b0;
            src_dn_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sink_idx_q  <= sink_idx_d;
            src_idx_q   <= src_idx_d;
            rem_q       <= rem_d;
            sink_dn_q   <= sink_dn_d;
            src_dn_q    <= src_dn_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_sink_idx = sink_idx_q;
    assign bus.out_src_idx  = src_idx_q;
    assign err_pulse        = err_pulse_q;
    assign err_count        = err_count_q;
    assign busy             = (state_q == EXPAND);

endmodule

// File: tb/tb_assign_range_expander.sv
// Self-checking bench for assign_range_expander.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by the stimulus; beats checked against a queue of expected beats.
module tb_assign_range_expander;
    localparam int IDX_W = 8;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    assign_range_if #(.IDX_W(IDX_W)) bus ();
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             busy;

    assign_range_expander #(.IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .busy      (busy)
    );

    typedef struct packed {
        logic [IDX_W-1:0] s;
        logic [IDX_W-1:0] r;
        logic             l;
    } beat_t;

    beat_t sb[$];
    int    checks     = 0;
    int    errors     = 0;
    int    beats_seen = 0;
    int    pulses     = 0;
    int    exp_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Beat monitor: every handshaken beat is popped from the scoreboard and compared.
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst) begin
            if (err_pulse) pulses++;
            if (bus.out_valid && bus.out_ready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("beat_sink", 32'(bus.out_sink_idx), 32'(e.s));
                    check("beat_src",  32'(bus.out_src_idx),  32'(e.r));
                    check("beat_last", 32'(bus.out_last),     32'(e.l));
                end
            end
        end
    end

    function automatic int width_of(input int msb, input int lsb);
        return (msb >= lsb ? msb - lsb : lsb - msb) + 1;
    endfunction

    task automatic push_beats(input int sm, input int sl, input int rm, input int rl);
        int    w;
        beat_t b;
        w = width_of(sm, sl);
        for (int k = 0; k < w; k++) begin
            b.s = IDX_W'(sm >= sl ? sm - k : sm + k);
            b.r = IDX_W'(rm >= rl ? rm - k : rm + k);
            b.l = (k == w - 1);
            sb.push_back(b);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int sm, input int sl, input int rm, input int rl);
        int n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.in_sink_msb = IDX_W'(sm);
        bus.in_sink_lsb = IDX_W'(sl);
        bus.in_src_msb  = IDX_W'(rm);
        bus.in_src_lsb  = IDX_W'(rl);
        do begin
            @(negedge clk);
            n++;
            if (!bus.in_ready) @(posedge clk);
        end while (!bus.in_ready && n < 1000);
        if (!bus.in_ready) begin
            check("send_timeout", 32'(0), 32'(1));
        end else if (width_of(sm, sl) == width_of(rm, rl)) begin
            push_beats(sm, sl, rm, rl);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts cycles from accept until in_ready returns; checks first-cycle outputs.
    task automatic wait_idle(input bit exp_beats, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_beat_vld", 32'(bus.out_valid), 32'(exp_beats));
                check("busy",           32'(busy),          32'(exp_beats));
            end
        end while (!bus.in_ready && cyc < 2000);
        if (!bus.in_ready) check("idle_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_rec(input int sm, input int sl, input int rm, input int rl, input int exp_cyc);
        int cyc;
        send(sm, sl, rm, rl);
        wait_idle(width_of(sm, sl) == width_of(rm, rl), cyc);
        check("ready_lat", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic reject_once();
        int p0;
        p0 = pulses;
        run_rec(3, 2, 1, 1, 2);
        if (exp_err < (1 << ERR_W) - 1) exp_err++;
        check("err_pulse_cycles", 32'(pulses - p0), 32'(1));
        check("err_count",        32'(err_count),   32'(exp_err));
    endtask

    initial begin
        int n;
        int b0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sink_msb = '0;
        bus.in_sink_lsb = '0;
        bus.in_src_msb  = '0;
        bus.in_src_lsb  = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),     32'(0));
        check("rst_out_valid", 32'(bus.out_valid),    32'(0));
        check("rst_out_last",  32'(bus.out_last),     32'(0));
        check("rst_sink_idx",  32'(bus.out_sink_idx), 32'(0));
        check("rst_src_idx",   32'(bus.out_src_idx),  32'(0));
        check("rst_err_cnt",   32'(err_count),        32'(0));
        check("rst_err_pulse", 32'(err_pulse),        32'(0));
        check("rst_busy",      32'(busy),             32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Equal, offset, single-bit, direction mismatch
        run_rec(3, 2, 3, 2, 3);
        run_rec(3, 2, 1, 0, 3);
        run_rec(3, 3, 1, 1, 2);
        run_rec(3, 0, 0, 3, 5);

        // Width mismatch, then saturation of the error counter
        reject_once();
        for (int i = 0; i < (1 << ERR_W) + 2; i++) reject_once();
        check("err_sat", 32'(err_count), 32'((1 << ERR_W) - 1));

        // Backpressure: hold beat (6,2) for three cycles
        send(7, 4, 3, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid),    32'(1));
            check("bp_sink",  32'(bus.out_sink_idx), 32'(6));
            check("bp_src",   32'(bus.out_src_idx),  32'(2));
            check("bp_last",  32'(bus.out_last),     32'(0));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        begin
            int cyc;
            wait_idle(1'b1, cyc);
        end
        check("bp_drained", 32'(sb.size()), 32'(0));

        // Full-range boundary
        run_rec(255, 0, 0, 255, 257);
        check("full_drained", 32'(sb.size()), 32'(0));

        // Reset in the middle of an expansion
        b0 = beats_seen;
        send(255, 0, 0, 255);
        n = 0;
        while (beats_seen < b0 + 11 && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        check("mid_beats", 32'(beats_seen - b0), 32'(11));
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_out_valid", 32'(bus.out_valid), 32'(0));
        check("mid_out_last",  32'(bus.out_last),  32'(0));
        check("mid_in_ready",  32'(bus.in_ready),  32'(1));
        check("mid_busy",      32'(busy),          32'(0));
        check("mid_err_cnt",   32'(err_count),     32'(0));
        @(posedge clk);
        #1;

        // Recovery after reset
        run_rec(1, 0, 1, 0, 3);
        check("final_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
